imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory read path: receives a byte stream, assembles little-endian 32-bit words and issues one-cycle write strobes into instruction memory.
- Holds the core in reset (core_hold) until the image is complete.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port; the core only reads instruction memory once done is set.

Parameters:
- ADDR_WIDTH, 8, word-address bits of instruction memory; depth = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load when idle or done.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts byte_in this cycle; transfer = byte_valid & byte_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of write, BASE_ADDR + 4*word_idx.
- mem_wdata  output  32  assembled word.
- core_hold  output  1  held high to keep the core in reset during load.
- done  output  1  load finished; level, stays high until next start.
- error  output  1  header length exceeded depth; valid when done=1.
- words_loaded  output  16  number of words written so far.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_hold=1, done=0, error=0, words_loaded=0, byte counter=0.
- Frame format: 2-byte little-endian word count N, then 4*N bytes; each word is little-endian (first byte -> bits 7:0).
- States: IDLE, LEN0, LEN1, DATA, WRITE, DONE.
- IDLE: byte_ready=0. start -> LEN0; clear done, error, words_loaded; core_hold=1.
- LEN0: byte_ready=1; on transfer, latch N[7:0] -> LEN1.
- LEN1: byte_ready=1; on transfer, latch N[15:8]. Then:
  - N=0 -> DONE, error=0.
  - N > 2**ADDR_WIDTH -> DONE, error=1, no writes.
  - otherwise -> DATA.
- DATA: byte_ready=1; each transfer shifts the byte into lane byte_cnt (0..3).
  - On the 4th byte -> WRITE; the assembled word is registered on mem_wdata.
- WRITE: byte_ready=0 (backpressure); mem_we=1 for exactly one cycle with mem_addr=BASE_ADDR+4*words_loaded.
  - Next edge: words_loaded++, byte_cnt=0.
  - If words_loaded+1 == N -> DONE, else -> DATA.
- Throughput: 5 cycles per word minimum (4 accept + 1 write).
- DONE: byte_ready=0, mem_we=0, done=1, core_hold=0 (core released on the same cycle done rises). start -> LEN0 with the IDLE clearing actions, core_hold=1 again.
- start in LEN0/LEN1/DATA/WRITE is ignored.
- byte_valid while byte_ready=0: byte not consumed; source must hold it.
- Arithmetic: mem_addr computed with 32-bit wrap; words_loaded is 16 bits, and N <= 2**ADDR_WIDTH guarantees no overflow for ADDR_WIDTH <= 16.
- Reset mid-load: returns to IDLE with core_hold=1; partial words are discarded; already-written memory is not cleared.
- mem_we is never asserted in the same cycle as byte_ready.

Decomposition:
- Shared package imem_loader_pkg: state enum (IDLE, LEN0, LEN1, DATA, WRITE, DONE) and a constant for header length (2 bytes).
- One sub-module is natural: word_assembler (byte-lane shift register plus 2-bit byte counter, with load/clear inputs and a word_full output).
- FSM and address/count registers stay in imem_loader.

Test Plan:
- Reset then start, stream 02 00 13 00 50 00 93 00 A0 00 -> mem_we pulses twice: addr 0x0 data 0x00500013, then addr 0x4 data 0x00A00093; words_loaded=2; done=1, core_hold=0, error=0.
- start, stream 00 00 -> no mem_we; done=1 one cycle after the second byte; error=0.
- ADDR_WIDTH=8, header 01 01 (N=257) -> no writes, done=1, error=1, core_hold=0.
- byte_valid held high continuously over a 3-word load -> byte_ready low exactly in each WRITE cycle; no byte lost or duplicated; 15 cycles from first byte to last write.
- Assert reset low after 6 data bytes (1 word written) -> all outputs at reset values immediately (asynchronous); a fresh load after start rewrites from BASE_ADDR.
- Pulse start during DATA, and again after done -> first pulse ignored (load completes normally); second pulse clears done, sets core_hold=1 and re-enters LEN0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and frame-format constants.
package imem_loader_pkg;

  // Loader FSM states, in the order a normal load visits them.
  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE
  } state_t;

  // Bytes in the little-endian word-count header that precedes the image.
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-lane shift register: collects four stream bytes into one
// little-endian 32-bit word (first byte lands in bits 7:0).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  byte_cnt;
  logic [31:0] lanes;

  // Drop each accepted byte into its lane and advance the lane counter.
  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: the lane register is reset even though it is datapath, because it
  // drives the write-data port, which must read zero while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (load) begin
      lanes[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt                       <= byte_cnt + 2'd1;
    end
  end

  // High on the transfer that completes the word (lane 3 being filled).
  assign word_full = load && (byte_cnt == 2'd3);
  assign word      = lanes;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes
// little-endian words into instruction memory and holds the core in reset
// until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // Largest image (in words) that fits in instruction memory.
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_t      state;
  state_t      next_state;
  logic [15:0] n_words;
  logic        transfer;
  logic        take_start;
  logic [15:0] n_full;
  logic        len_over;
  logic [15:0] words_next;
  logic        word_full;

  assign transfer   = byte_valid && byte_ready;
  assign take_start = start && ((state == IDLE) || (state == DONE));
  // Full header value as it becomes known on the second header byte.
  assign n_full     = {byte_in, n_words[7:0]};
  assign len_over   = 32'(n_full) > DEPTH;
  assign words_next = words_loaded + 16'd1;
  assign mem_addr   = BASE_ADDR + {14'd0, words_loaded, 2'b00};

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (take_start || (state == WRITE)),
    .load      ((state == DATA) && transfer),
    .byte_in   (byte_in),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode and state-derived handshake/status outputs.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    core_hold  = 1'b1;
    case (state)
      IDLE: begin
        if (start) next_state = LEN0;
      end
      LEN0: begin
        byte_ready = 1'b1;
        if (transfer) next_state = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        if (transfer) begin
          if ((n_full == 16'd0) || len_over) next_state = DONE;
          else                               next_state = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (word_full) next_state = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        next_state = (words_next == n_words) ? DONE : DATA;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) next_state = LEN0;
      end
      default: next_state = IDLE;
    endcase
  end

  // Header length, error flag and written-word count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words      <= '0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (take_start) begin
        error        <= 1'b0;
        words_loaded <= '0;
      end
      if ((state == LEN0) && transfer) n_words[7:0] <= byte_in;
      if ((state == LEN1) && transfer) begin
        n_words[15:8] <= byte_in;
        error         <= len_over;
      end
      if (state == WRITE) words_loaded <= words_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a driver streams frames while a monitor
// pops expected writes from a scoreboard queue on every mem_we.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int we_cyc = 0;
  int first_cyc = 0;
  wr_t exp_q[$];
  logic [7:0] tx_q[$];

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset && mem_we) begin
      we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, mem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("we_with_ready", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  // Present one byte and hold it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!byte_ready) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  // Stream tx_q back to back; remembers when the first data byte was accepted.
  task automatic send_stream();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      if (i == 2) first_cyc = acc_cyc;
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Two-word image.
    exp_q.push_back('{addr: 32'h0, data: 32'h0050_0013});
    exp_q.push_back('{addr: 32'h4, data: 32'h00A0_0093});
    pulse_start();
    check("t1_ready_len0", {31'd0, byte_ready}, 32'd1);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    send_stream();
    wait_done();
    check("t1_words", {16'd0, words_loaded}, 32'd2);
    check("t1_core_hold", {31'd0, core_hold}, 32'd0);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty image: done the cycle after the second header byte.
    pulse_start();
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    check("t2_core_hold", {31'd0, core_hold}, 32'd1);
    check("t2_words_cleared", {16'd0, words_loaded}, 32'd0);
    tx_q = '{8'h00, 8'h00};
    send_stream();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_error", {31'd0, error}, 32'd0);
    check("t2_words", {16'd0, words_loaded}, 32'd0);

    // Oversized header (257 > 256 words).
    pulse_start();
    tx_q = '{8'h01, 8'h01};
    send_stream();
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_core_hold", {31'd0, core_hold}, 32'd0);
    check("t3_words", {16'd0, words_loaded}, 32'd0);

    // Three words with byte_valid held high: 15 cycles first byte to last write.
    exp_q.push_back('{addr: 32'h0, data: 32'h1122_3344});
    exp_q.push_back('{addr: 32'h4, data: 32'hDEAD_BEEF});
    exp_q.push_back('{addr: 32'h8, data: 32'h0000_0001});
    pulse_start();
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    tx_q = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
             8'h01, 8'h00, 8'h00, 8'h00};
    send_stream();
    wait_done();
    check("t4_span", 32'(we_cyc - first_cyc), 32'd14);
    check("t4_words", {16'd0, words_loaded}, 32'd3);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset after six data bytes, then reload from BASE_ADDR.
    exp_q.push_back('{addr: 32'h0, data: 32'h0BAD_C0DE});
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'hDE, 8'hC0, 8'hAD, 8'h0B, 8'h11, 8'h22};
    send_stream();
    check("t5_words_mid", {16'd0, words_loaded}, 32'd1);
    reset = 1'b0;
    #1;
    check("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_mem_we", {31'd0, mem_we}, 32'd0);
    check("t5_mem_addr", mem_addr, 32'h0);
    check("t5_mem_wdata", mem_wdata, 32'h0);
    check("t5_core_hold", {31'd0, core_hold}, 32'd1);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_words", {16'd0, words_loaded}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_F00D});
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_stream();
    wait_done();
    check("t5_reload_words", {16'd0, words_loaded}, 32'd1);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // start during DATA is ignored; start after done re-arms the loader.
    exp_q.push_back('{addr: 32'h0, data: 32'h89AB_CDEF});
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'hEF, 8'hCD};
    send_stream();
    pulse_start();
    check("t6_hold_in_data", {31'd0, core_hold}, 32'd1);
    tx_q = '{8'hAB, 8'h89};
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i]);
    byte_valid = 1'b0;
    wait_done();
    check("t6_words", {16'd0, words_loaded}, 32'd1);
    check("t6_error", {31'd0, error}, 32'd0);
    pulse_start();
    check("t6_done_cleared", {31'd0, done}, 32'd0);
    check("t6_core_hold", {31'd0, core_hold}, 32'd1);
    check("t6_ready_len0", {31'd0, byte_ready}, 32'd1);
    check("t6_words_cleared", {16'd0, words_loaded}, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
